// File: rtl/l1_servo_master_if.sv
// Wishbone initiator bus between the L1 servo master and the L1 register space.
interface l1_servo_master_if;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [12:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i;
    logic        m_err_i;
    logic        m_rty_i;
    logic [31:0] m_dat_i;

    modport master (
        output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o,
        input  m_ack_i, m_err_i, m_rty_i, m_dat_i
    );

    modport slave (
        input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o,
        output m_ack_i, m_err_i, m_rty_i, m_dat_i
    );
endinterface

// File: rtl/l1_servo_master.sv
// L1 threshold servo: after each scaler period, reads every beam's count, nudges its
// threshold toward the target rate, writes it back and strobes the threshold update.
module l1_servo_master #(
    parameter int          NBEAMS      = 2,
    parameter logic [17:0] THRESH_INIT = 18'h10000,
    parameter logic [17:0] STEP        = 18'd16,
    parameter int          TIMEOUT     = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    l1_servo_master_if.master bus,
    input  logic              count_done_i,
    input  logic              enable_i,
    input  logic [31:0]       target_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int             BW        = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
    localparam logic [BW-1:0]  LAST_BEAM = BW'(NBEAMS - 1);
    localparam logic [BW-1:0]  BEAM_ONE  = BW'(1);
    localparam logic [7:0]     TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [12:0]    RD_BASE   = 13'h0400;
    localparam logic [12:0]    WR_BASE   = 13'h0800;
    localparam logic [12:0]    UPD_ADR   = 13'h1800;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CALC = 3'd2,
        ST_WR   = 3'd3,
        ST_UPD  = 3'd4,
        ST_NEXT = 3'd5
    } state_t;

    state_t        state_r, next_state_s;
    logic [BW-1:0] beam_r, beam_nxt_s;
    logic [31:0]   count_r;
    logic [17:0]   thr_r [NBEAMS];
    logic [7:0]    tmo_r;
    logic          act_r, act_nxt_s;
    logic          we_r, we_nxt_s;
    logic [12:0]   adr_r, adr_nxt_s;
    logic [31:0]   dat_r, dat_nxt_s;
    logic          busy_r, done_r, error_r;
    logic          done_nxt_s, err_set_s, latch_cnt_s, commit_thr_s, tmo_clr_s;
    logic          resp_err_s, resp_rty_s, resp_ack_s, tmo_fire_s;
    logic [17:0]   calc_thr_s;

    function automatic logic [12:0] beam_adr(input logic [12:0] base, input logic [BW-1:0] b);
        return base + (13'(b) << 2);
    endfunction

    // Saturating one-step move of a threshold toward the target count.
    function automatic logic [17:0] next_thr(input logic [17:0] thr,
                                             input logic [31:0] cnt,
                                             input logic [31:0] tgt);
        logic [18:0] sum_v;
        sum_v = {1'b0, thr} + {1'b0, STEP};
        if (cnt > tgt) begin
            next_thr = sum_v[18] ? 18'h3FFFF : sum_v[17:0];
        end else if (cnt < tgt) begin
            next_thr = (thr < STEP) ? 18'h00000 : (thr - STEP);
        end else begin
            next_thr = thr;
        end
    endfunction

    // Error outranks retry, retry outranks ack; timeout only when the target stays silent.
    assign resp_err_s = act_r & bus.m_err_i;
    assign resp_rty_s = act_r & ~bus.m_err_i & bus.m_rty_i;
    assign resp_ack_s = act_r & ~bus.m_err_i & ~bus.m_rty_i & bus.m_ack_i;
    assign tmo_fire_s = act_r & ~(bus.m_err_i | bus.m_rty_i | bus.m_ack_i) & (tmo_r == TMO_LAST);
    assign calc_thr_s = next_thr(thr_r[beam_r], count_r, target_i);

    // Next-state and next-bus-value decode.
    always_comb begin
        next_state_s = state_r;
        act_nxt_s    = act_r;
        we_nxt_s     = we_r;
        adr_nxt_s    = adr_r;
        dat_nxt_s    = dat_r;
        beam_nxt_s   = beam_r;
        done_nxt_s   = 1'b0;
        err_set_s    = 1'b0;
        latch_cnt_s  = 1'b0;
        commit_thr_s = 1'b0;
        tmo_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_done_i && enable_i && !error_r) begin
                    next_state_s = ST_RD;
                    beam_nxt_s   = {BW{1'b0}};
                    act_nxt_s    = 1'b1;
                    we_nxt_s     = 1'b0;
                    adr_nxt_s    = RD_BASE;
                    dat_nxt_s    = 32'h0000_0000;
                    tmo_clr_s    = 1'b1;
                end else begin
                    act_nxt_s    = 1'b0;
                end
            end
            ST_RD, ST_WR, ST_UPD: begin
                if (!act_r) begin
                    // Second half of a retry gap: reissue the held access.
                    act_nxt_s = 1'b1;
                    tmo_clr_s = 1'b1;
                end else if (resp_err_s || tmo_fire_s) begin
                    act_nxt_s    = 1'b0;
                    we_nxt_s     = 1'b0;
                    dat_nxt_s    = 32'h0000_0000;
                    err_set_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (resp_rty_s) begin
                    act_nxt_s = 1'b0;
                end else if (resp_ack_s) begin
                    act_nxt_s = 1'b0;
                    we_nxt_s  = 1'b0;
                    dat_nxt_s = 32'h0000_0000;
                    case (state_r)
                        ST_RD: begin
                            latch_cnt_s  = 1'b1;
                            next_state_s = ST_CALC;
                        end
                        ST_WR: begin
                            commit_thr_s = 1'b1;
                            next_state_s = ST_NEXT;
                        end
                        default: begin
                            done_nxt_s   = 1'b1;
                            next_state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    act_nxt_s = 1'b1;
                end
            end
            ST_CALC: begin
                next_state_s = ST_WR;
                act_nxt_s    = 1'b1;
                we_nxt_s     = 1'b1;
                adr_nxt_s    = beam_adr(WR_BASE, beam_r);
                dat_nxt_s    = {14'h0000, calc_thr_s};
                tmo_clr_s    = 1'b1;
            end
            ST_NEXT: begin
                act_nxt_s = 1'b1;
                tmo_clr_s = 1'b1;
                if (beam_r != LAST_BEAM) begin
                    next_state_s = ST_RD;
                    beam_nxt_s   = beam_r + BEAM_ONE;
                    we_nxt_s     = 1'b0;
                    adr_nxt_s    = beam_adr(RD_BASE, beam_r + BEAM_ONE);
                    dat_nxt_s    = 32'h0000_0000;
                end else begin
                    next_state_s = ST_UPD;
                    we_nxt_s     = 1'b1;
                    adr_nxt_s    = UPD_ADR;
                    dat_nxt_s    = 32'h0000_0001;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                act_nxt_s    = 1'b0;
                we_nxt_s     = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered bus drive and status outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            act_r   <= 1'b0;
            we_r    <= 1'b0;
            adr_r   <= 13'h0000;
            dat_r   <= 32'h0000_0000;
            beam_r  <= {BW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            act_r   <= act_nxt_s;
            we_r    <= we_nxt_s;
            adr_r   <= adr_nxt_s;
            dat_r   <= dat_nxt_s;
            beam_r  <= beam_nxt_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= done_nxt_s;
            error_r <= error_r | err_set_s;
        end
    end

    // Response watchdog, restarted on every strobe assertion.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_r <= 8'h00;
        end else if (tmo_clr_s) begin
            tmo_r <= 8'h00;
        end else if (act_r) begin
            tmo_r <= tmo_r + 8'h01;
        end else begin
            tmo_r <= tmo_r;
        end
    end

    // Scaler count capture and per-beam threshold store; a threshold changes only once its write is acked.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            count_r <= 32'h0000_0000;
            for (int i = 0; i < NBEAMS; i++) begin
                thr_r[i] <= THRESH_INIT;
            end
        end else begin
            if (latch_cnt_s) begin
                count_r <= bus.m_dat_i;
            end else begin
                count_r <= count_r;
            end
            if (commit_thr_s) begin
                thr_r[beam_r] <= dat_r[17:0];
            end
        end
    end

    assign bus.m_cyc_o = act_r;
    assign bus.m_stb_o = act_r;
    assign bus.m_we_o  = we_r;
    assign bus.m_adr_o = adr_r;
    assign bus.m_dat_o = dat_r;
    assign bus.m_sel_o = 4'hF;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign error_o     = error_r;

endmodule

// File: tb/tb_l1_servo_master.sv
// Directed bench for l1_servo_master: a negedge-driven Wishbone target logs every response.
module tb_l1_servo_master;

    typedef struct {
        logic [1:0]  kind;
        logic        we;
        logic [12:0] adr;
        logic [31:0] dat;
        int          cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        count_done = 1'b0;
    logic        sat_go = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] target = 32'd100;
    logic        busy, done, error;
    logic        busy_hi, done_hi, error_hi;
    logic        busy_lo, done_lo, error_lo;

    int   errors = 0;
    int   checks = 0;
    int   ncyc = 0;
    int   done_cnt = 0;
    int   bb_viol = 0;
    txn_t log_q[$];

    logic        hang_rd = 1'b0;
    logic [31:0] rd_d0 = 32'd200;
    logic [31:0] rd_d1 = 32'd50;
    int          rty_req = 0, rty_srv = 0;
    logic [12:0] rty_adr = 13'h0000;
    int          err_req = 0, err_srv = 0;
    logic [12:0] err_adr = 13'h0000;

    logic [31:0] hi_wr = 32'h0, lo_wr = 32'h0;
    int          hi_wr_n = 0, lo_wr_n = 0;

    always #5 clk = ~clk;

    l1_servo_master_if bus ();
    l1_servo_master_if bus_hi ();
    l1_servo_master_if bus_lo ();

    l1_servo_master dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus),
        .count_done_i(count_done), .enable_i(enable), .target_i(target),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    l1_servo_master #(.NBEAMS(1), .THRESH_INIT(18'h3FFF8)) dut_hi (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus_hi),
        .count_done_i(sat_go), .enable_i(enable), .target_i(target),
        .busy_o(busy_hi), .done_o(done_hi), .error_o(error_hi)
    );

    l1_servo_master #(.NBEAMS(1), .THRESH_INIT(18'h00008)) dut_lo (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus_lo),
        .count_done_i(sat_go), .enable_i(enable), .target_i(target),
        .busy_o(busy_lo), .done_o(done_lo), .error_o(error_lo)
    );

    // Main target: one-cycle responses, logged with the negedge index they were given on.
    initial begin
        txn_t t;
        bus.m_ack_i = 1'b0; bus.m_err_i = 1'b0; bus.m_rty_i = 1'b0; bus.m_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (done) done_cnt++;
            if (bus.m_ack_i || bus.m_rty_i || bus.m_err_i) begin
                if (bus.m_cyc_o) bb_viol++;
                bus.m_ack_i = 1'b0; bus.m_err_i = 1'b0; bus.m_rty_i = 1'b0;
            end else if (bus.m_cyc_o && bus.m_stb_o && !(hang_rd && !bus.m_we_o)) begin
                t.we = bus.m_we_o; t.adr = bus.m_adr_o; t.dat = bus.m_dat_o; t.cyc = ncyc;
                if (err_req != err_srv && bus.m_adr_o == err_adr) begin
                    err_srv = err_req; bus.m_err_i = 1'b1; t.kind = 2'd2;
                end else if (rty_req != rty_srv && bus.m_adr_o == rty_adr) begin
                    rty_srv = rty_req; bus.m_rty_i = 1'b1; t.kind = 2'd1;
                end else begin
                    bus.m_ack_i = 1'b1; t.kind = 2'd0;
                    bus.m_dat_i = (bus.m_adr_o == 13'h0404) ? rd_d1 : rd_d0;
                end
                log_q.push_back(t);
            end
        end
    end

    // Saturation targets: always ack, fixed read counts 200 and 50, capture threshold writes.
    initial begin
        bus_hi.m_ack_i = 1'b0; bus_hi.m_err_i = 1'b0; bus_hi.m_rty_i = 1'b0; bus_hi.m_dat_i = 32'd200;
        bus_lo.m_ack_i = 1'b0; bus_lo.m_err_i = 1'b0; bus_lo.m_rty_i = 1'b0; bus_lo.m_dat_i = 32'd50;
        forever begin
            @(negedge clk);
            if (bus_hi.m_ack_i) bus_hi.m_ack_i = 1'b0;
            else if (bus_hi.m_cyc_o && bus_hi.m_stb_o) begin
                bus_hi.m_ack_i = 1'b1;
                if (bus_hi.m_we_o && bus_hi.m_adr_o == 13'h0800) begin hi_wr = bus_hi.m_dat_o; hi_wr_n++; end
            end
            if (bus_lo.m_ack_i) bus_lo.m_ack_i = 1'b0;
            else if (bus_lo.m_cyc_o && bus_lo.m_stb_o) begin
                bus_lo.m_ack_i = 1'b1;
                if (bus_lo.m_we_o && bus_lo.m_adr_o == 13'h0800) begin lo_wr = bus_lo.m_dat_o; lo_wr_n++; end
            end
        end
    end

    function automatic logic [47:0] mk(input logic [1:0] k, input logic w,
                                       input logic [12:0] a, input logic [31:0] d);
        return {k, w, a, d};
    endfunction

    function automatic logic [47:0] pk(input txn_t t);
        return {t.kind, t.we, t.adr, t.dat};
    endfunction

    task automatic pulse_main();
        @(negedge clk); count_done = 1'b1;
        @(negedge clk); count_done = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        @(negedge clk);
        while ((busy || busy_hi || busy_lo) && k < 1000) begin @(negedge clk); k++; end
        checks++;
        if (k >= 1000) begin errors++; $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", nm, busy, k); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, busy, done, error} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl: got %b required 000000", {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, busy, done, error});
        end
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_adr_o !== 13'h0 || bus.m_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_adr_dat: got %h/%h required 0000/00000000", bus.m_adr_o, bus.m_dat_o);
        end
        checks++;
        if (bus.m_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h required f", bus.m_sel_o); end
        checks++;
        if ({busy, done, error, bus.m_cyc_o} !== 4'b0) begin
            errors++; $display("FAIL reset_released: got %b required 0000", {busy, done, error, bus.m_cyc_o});
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 2; p++) begin
            @(negedge clk); sat_go = 1'b1;
            @(negedge clk); sat_go = 1'b0;
            wait_idle("sat");
            checks++;
            if (hi_wr !== 32'h0003FFFF || hi_wr_n !== p + 1) begin
                errors++; $display("FAIL sat_high_pass%0d: got %h (n=%0d) required 0003ffff (n=%0d)", p, hi_wr, hi_wr_n, p + 1);
            end
            checks++;
            if (lo_wr !== 32'h00000000 || lo_wr_n !== p + 1) begin
                errors++; $display("FAIL sat_low_pass%0d: got %h (n=%0d) required 00000000 (n=%0d)", p, lo_wr, lo_wr_n, p + 1);
            end
        end
    endtask

    task automatic test_basic();
        int base; int db; logic [47:0] got; logic [47:0] exp_q[$];
        rd_d0 = 32'd200; rd_d1 = 32'd50; base = log_q.size(); db = done_cnt;
        pulse_main(); wait_idle("basic");
        exp_q = '{mk(2'd0, 1'b0, 13'h0400, 32'h0), mk(2'd0, 1'b1, 13'h0800, 32'h10010),
                  mk(2'd0, 1'b0, 13'h0404, 32'h0), mk(2'd0, 1'b1, 13'h0804, 32'h0FFF0),
                  mk(2'd0, 1'b1, 13'h1800, 32'h1)};
        checks++;
        if (log_q.size() - base !== 5) begin errors++; $display("FAIL basic_count: got %0d required 5", log_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < log_q.size()) ? pk(log_q[base + i]) : 48'hFFFF_FFFF_FFFF;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL basic_txn%0d: got %h required %h", i, got, exp_q[i]); end
        end
        checks++;
        if (done_cnt - db !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt - db); end
    endtask

    task automatic test_equal();
        int base; logic [47:0] got; logic [47:0] exp_q[$];
        rd_d0 = 32'd100; rd_d1 = 32'd150; base = log_q.size();
        pulse_main(); wait_idle("equal");
        exp_q = '{mk(2'd0, 1'b1, 13'h0800, 32'h10010), mk(2'd0, 1'b1, 13'h0804, 32'h10000)};
        for (int i = 0; i < 2; i++) begin
            got = (base + 1 + 2 * i < log_q.size()) ? pk(log_q[base + 1 + 2 * i]) : 48'hFFFF_FFFF_FFFF;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL equal_wr%0d: got %h required %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_enable_gate();
        int base;
        base = log_q.size(); enable = 1'b0;
        pulse_main(); repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || log_q.size() !== base) begin
            errors++; $display("FAIL enable_gate: busy=%b new_txn=%0d required 0/0", busy, log_q.size() - base);
        end
        enable = 1'b1;
    endtask

    task automatic test_busy_pulse();
        int base; int db; int k = 0; logic [47:0] got;
        rd_d0 = 32'd200; rd_d1 = 32'd50; base = log_q.size(); db = done_cnt;
        pulse_main();
        while (!(bus.m_cyc_o && bus.m_adr_o == 13'h0404) && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (k >= 50) begin errors++; $display("FAIL busy_rd1_seen: waited %0d cycles required <50", k); end
        count_done = 1'b1; @(negedge clk); count_done = 1'b0;
        wait_idle("busy_pulse"); repeat (5) @(negedge clk);
        checks++;
        if (log_q.size() - base !== 5 || done_cnt - db !== 1) begin
            errors++; $display("FAIL busy_no_extra: txns=%0d done=%0d required 5/1", log_q.size() - base, done_cnt - db);
        end
        got = (base + 3 < log_q.size()) ? pk(log_q[base + 3]) : 48'hFFFF_FFFF_FFFF;
        checks++;
        if (got !== mk(2'd0, 1'b1, 13'h0804, 32'h0FFF0)) begin
            errors++; $display("FAIL busy_wr1: got %h required %h", got, mk(2'd0, 1'b1, 13'h0804, 32'h0FFF0));
        end
    endtask

    task automatic test_retry();
        int base; int db; logic [47:0] got; logic [47:0] exp_q[$];
        rd_d0 = 32'd200; rd_d1 = 32'd50; base = log_q.size(); db = done_cnt;
        rty_adr = 13'h0804; rty_req++;
        pulse_main(); wait_idle("retry");
        exp_q = '{mk(2'd0, 1'b0, 13'h0400, 32'h0), mk(2'd0, 1'b1, 13'h0800, 32'h10030),
                  mk(2'd0, 1'b0, 13'h0404, 32'h0), mk(2'd1, 1'b1, 13'h0804, 32'h0FFE0),
                  mk(2'd0, 1'b1, 13'h0804, 32'h0FFE0), mk(2'd0, 1'b1, 13'h1800, 32'h1)};
        checks++;
        if (log_q.size() - base !== 6) begin errors++; $display("FAIL retry_count: got %0d required 6", log_q.size() - base); end
        for (int i = 0; i < 6; i++) begin
            got = (base + i < log_q.size()) ? pk(log_q[base + i]) : 48'hFFFF_FFFF_FFFF;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL retry_txn%0d: got %h required %h", i, got, exp_q[i]); end
        end
        if (log_q.size() - base >= 5) begin
            checks++;
            if (log_q[base + 4].cyc - log_q[base + 3].cyc !== 2) begin
                errors++; $display("FAIL retry_gap: reissue after %0d cycles required 2", log_q[base + 4].cyc - log_q[base + 3].cyc);
            end
        end
        checks++;
        if (done_cnt - db !== 1 || bb_viol !== 0) begin
            errors++; $display("FAIL retry_done: done=%0d b2b=%0d required 1/0", done_cnt - db, bb_viol);
        end
    endtask

    task automatic test_timeout();
        int n = 0; int db; int base;
        hang_rd = 1'b1; db = done_cnt;
        pulse_main();
        while (bus.m_cyc_o && n < 400) begin n++; @(negedge clk); end
        checks++;
        if (n !== 255) begin errors++; $display("FAIL timeout_len: cyc held %0d cycles required 255", n); end
        checks++;
        if ({error, busy} !== 2'b10 || done_cnt !== db) begin
            errors++; $display("FAIL timeout_status: error/busy=%b done=%0d required 10/0", {error, busy}, done_cnt - db);
        end
        hang_rd = 1'b0; base = log_q.size();
        pulse_main(); repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || log_q.size() !== base || error !== 1'b1) begin
            errors++; $display("FAIL timeout_locked: busy=%b txns=%0d error=%b required 0/0/1", busy, log_q.size() - base, error);
        end
    endtask

    task automatic test_reset_mid();
        int base; int k = 0; logic [47:0] got; logic [47:0] exp_q[$];
        @(negedge clk); rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1; @(negedge clk);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL rst_clears_error: got %b required 0", error); end
        rd_d0 = 32'd200; rd_d1 = 32'd50;
        pulse_main();
        while (k < 50) begin
            @(posedge clk); #1;
            if (bus.m_cyc_o && bus.m_we_o && bus.m_adr_o == 13'h0800) break;
            k++;
        end
        checks++;
        if (k >= 50) begin errors++; $display("FAIL rst_wr_seen: waited %0d cycles required <50", k); end
        rst_n = 1'b0; #1;
        checks++;
        if ({bus.m_cyc_o, bus.m_stb_o, busy} !== 3'b000) begin
            errors++; $display("FAIL rst_async_drop: cyc/stb/busy=%b required 000", {bus.m_cyc_o, bus.m_stb_o, busy});
        end
        repeat (2) @(negedge clk); rst_n = 1'b1;
        base = log_q.size();
        pulse_main(); wait_idle("reset_mid");
        exp_q = '{mk(2'd0, 1'b0, 13'h0400, 32'h0), mk(2'd0, 1'b1, 13'h0800, 32'h10010),
                  mk(2'd0, 1'b0, 13'h0404, 32'h0), mk(2'd0, 1'b1, 13'h0804, 32'h0FFF0)};
        for (int i = 0; i < 4; i++) begin
            got = (base + i < log_q.size()) ? pk(log_q[base + i]) : 48'hFFFF_FFFF_FFFF;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL rst_txn%0d: got %h required %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_err();
        int base; int db; logic [47:0] got; logic [47:0] exp_q[$];
        rd_d0 = 32'd200; rd_d1 = 32'd50; base = log_q.size(); db = done_cnt;
        err_adr = 13'h0804; err_req++;
        pulse_main(); wait_idle("err");
        exp_q = '{mk(2'd0, 1'b0, 13'h0400, 32'h0), mk(2'd0, 1'b1, 13'h0800, 32'h10020),
                  mk(2'd0, 1'b0, 13'h0404, 32'h0), mk(2'd2, 1'b1, 13'h0804, 32'h0FFE0)};
        checks++;
        if (log_q.size() - base !== 4) begin errors++; $display("FAIL err_count: got %0d required 4", log_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < log_q.size()) ? pk(log_q[base + i]) : 48'hFFFF_FFFF_FFFF;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL err_txn%0d: got %h required %h", i, got, exp_q[i]); end
        end
        checks++;
        if (error !== 1'b1 || done_cnt !== db) begin
            errors++; $display("FAIL err_status: error=%b done=%0d required 1/0", error, done_cnt - db);
        end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_basic();
        test_equal();
        test_enable_gate();
        test_busy_pulse();
        test_retry();
        test_timeout();
        test_reset_mid();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
